// File: rtl/fpu_add.sv
// fpu_add: multi-cycle adder for a 32-bit custom float format
// {sign, exp[EXP_W-1:0], frac[FRAC_W-1:0]}, with a hidden leading one
// and no subnormals. A fixed five-state loop runs continuously:
// LOAD -> ALIGN -> ADD -> NORM -> ROUND. Each ROUND publishes a new
// result and status code.
module fpu_add #(
    parameter int EXP_W  = 10,
    parameter int FRAC_W = 21,
    parameter int BIAS   = 511
) (
    input  logic                    clock_100Khz,
    input  logic                    reset,
    input  logic [EXP_W+FRAC_W:0]   Op_A_in,
    input  logic [EXP_W+FRAC_W:0]   Op_B_in,
    output logic [EXP_W+FRAC_W:0]   data_out,
    output logic [3:0]              status_out
);

    localparam int W       = 1 + EXP_W + FRAC_W;   // word width
    localparam int MW      = FRAC_W + 1;           // significand incl. hidden one
    localparam int XW      = MW + 3;               // significand + guard/round/sticky
    localparam int SW      = XW + 1;               // sum with carry-out
    localparam int EXW     = EXP_W + 2;            // signed working exponent
    localparam int LZW     = $clog2(XW + 1);       // leading-zero count width
    localparam int EXP_MAX = 2 * BIAS + 1;         // all-ones exponent code: infinity

    localparam logic signed [EXW-1:0] EXP_MAX_S = EXW'(EXP_MAX);
    localparam logic signed [EXW-1:0] ONE_S     = EXW'(1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND
    } state_t;

    typedef enum logic [3:0] {
        ST_OVERFLOW  = 4'd0,
        ST_UNDERFLOW = 4'd1,
        ST_EXACT     = 4'd2,
        ST_INEXACT   = 4'd3
    } status_t;

    state_t state_q, state_d;

    // Pipeline-stage registers (one stage active per state)
    logic [W-1:0]            opa_q, opb_q;
    logic                    sign_q;
    logic                    eff_sub_q;
    logic                    inf_q;
    logic signed [EXW-1:0]   exp_q;
    logic [XW-1:0]           big_q, small_q;
    logic [SW-1:0]           sum_q;
    logic [XW-1:0]           norm_q;
    logic                    zero_q;
    logic [W-1:0]            data_q;
    status_t                 status_q;

    // ALIGN combinational signals
    logic [EXP_W-1:0]        exp_a, exp_b, big_exp, small_exp, exp_diff;
    logic [FRAC_W-1:0]       frac_a, frac_b;
    logic [MW-1:0]           mant_a, mant_b, big_mant, small_mant;
    logic                    a_big, big_sign, any_inf;
    logic [XW-1:0]           small_ext, shift_mask, shifted, aligned;

    // NORM combinational signals
    logic [LZW-1:0]          lz;
    logic [XW-1:0]           norm_d;
    logic signed [EXW-1:0]   exp_norm;
    logic                    sum_zero;

    // ROUND combinational signals
    logic [MW-1:0]           mant;
    logic                    g_bit, r_bit, s_bit, rnd_up, inexact;
    logic [MW:0]             mant_r;
    logic [FRAC_W-1:0]       frac_rnd;
    logic signed [EXW-1:0]   exp_rnd;
    logic [W-1:0]            res_data;
    status_t                 res_status;

    // FSM state register; reset aborts any computation in flight
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fixed cyclic sequence, one state per clock
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD:  state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // ALIGN: order operands by magnitude and right-shift the smaller one
    always_comb begin
        exp_a      = opa_q[W-2:FRAC_W];
        exp_b      = opb_q[W-2:FRAC_W];
        frac_a     = opa_q[FRAC_W-1:0];
        frac_b     = opb_q[FRAC_W-1:0];
        mant_a     = (exp_a == '0) ? '0 : {1'b1, frac_a};
        mant_b     = (exp_b == '0) ? '0 : {1'b1, frac_b};
        any_inf    = (exp_a == EXP_W'(EXP_MAX)) || (exp_b == EXP_W'(EXP_MAX));
        a_big      = {exp_a, frac_a} >= {exp_b, frac_b};
        big_sign   = a_big ? opa_q[W-1] : opb_q[W-1];
        big_exp    = a_big ? exp_a  : exp_b;
        small_exp  = a_big ? exp_b  : exp_a;
        big_mant   = a_big ? mant_a : mant_b;
        small_mant = a_big ? mant_b : mant_a;
        exp_diff   = big_exp - small_exp;
        small_ext  = {small_mant, 3'b000};
        shift_mask = ~({XW{1'b1}} << exp_diff);
        shifted    = '0;
        // Shifts past the whole extended significand collapse into sticky
        if (exp_diff >= EXP_W'(XW)) begin
            aligned = {{(XW-1){1'b0}}, |small_mant};
        end else begin
            shifted = small_ext >> exp_diff;
            aligned = {shifted[XW-1:1], shifted[0] | (|(small_ext & shift_mask))};
        end
    end

    // NORM: leading-zero count and renormalisation of the raw sum
    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < XW; i++) begin
            if (sum_q[i]) begin
                lz = LZW'(XW - 1 - i);
            end
        end
        sum_zero = (sum_q == '0);
        if (sum_q[SW-1]) begin
            norm_d   = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
            exp_norm = exp_q + ONE_S;
        end else begin
            norm_d   = sum_q[XW-1:0] << lz;
            exp_norm = exp_q - $signed({{(EXW-LZW){1'b0}}, lz});
        end
    end

    // ROUND: nearest-even rounding, then range checks in priority order
    always_comb begin
        mant     = norm_q[XW-1:3];
        g_bit    = norm_q[2];
        r_bit    = norm_q[1];
        s_bit    = norm_q[0];
        inexact  = g_bit | r_bit | s_bit;
        rnd_up   = g_bit & (r_bit | s_bit | mant[0]);
        mant_r   = {1'b0, mant} + {{MW{1'b0}}, rnd_up};
        frac_rnd = mant_r[MW] ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];
        exp_rnd  = mant_r[MW] ? exp_q + ONE_S : exp_q;

        res_data   = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
        res_status = inexact ? ST_INEXACT : ST_EXACT;
        if (inf_q || (!zero_q && exp_rnd >= EXP_MAX_S)) begin
            res_data   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            res_status = ST_OVERFLOW;
        end else if (zero_q) begin
            res_data   = '0;
            res_status = ST_EXACT;
        end else if (exp_rnd < ONE_S) begin
            res_data   = {sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
            res_status = ST_UNDERFLOW;
        end
    end

    // Datapath: each state loads the register set for its stage
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            opa_q     <= '0;
            opb_q     <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            inf_q     <= 1'b0;
            exp_q     <= '0;
            big_q     <= '0;
            small_q   <= '0;
            sum_q     <= '0;
            norm_q    <= '0;
            zero_q    <= 1'b0;
            data_q    <= '0;
            status_q  <= ST_EXACT;
        end else begin
            case (state_q)
                S_LOAD: begin
                    opa_q <= Op_A_in;
                    opb_q <= Op_B_in;
                end
                S_ALIGN: begin
                    sign_q    <= big_sign;
                    eff_sub_q <= opa_q[W-1] ^ opb_q[W-1];
                    inf_q     <= any_inf;
                    exp_q     <= {2'b00, big_exp};
                    big_q     <= {big_mant, 3'b000};
                    small_q   <= aligned;
                end
                S_ADD: begin
                    sum_q <= eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                       : ({1'b0, big_q} + {1'b0, small_q});
                end
                S_NORM: begin
                    norm_q <= norm_d;
                    exp_q  <= exp_norm;
                    zero_q <= sum_zero;
                end
                S_ROUND: begin
                    data_q   <= res_data;
                    status_q <= res_status;
                end
                default: ;
            endcase
        end
    end

    assign data_out   = data_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_fpu_add.sv
// Directed bench for fpu_add with hand-computed expected results.
`timescale 1ns/1ps
module tb_fpu_add;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [31:0] dout;
    logic [3:0]  st;
    int          total = 0;
    int          bad   = 0;

    localparam logic [3:0] OVF = 4'd0, UNF = 4'd1, EXA = 4'd2, INX = 4'd3;

    // 100 kHz clock
    always #5000 clk = ~clk;

    fpu_add dut (
        .clock_100Khz (clk),
        .reset        (rst_n),
        .Op_A_in      (a),
        .Op_B_in      (b),
        .data_out     (dout),
        .status_out   (st)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Hold operands well beyond one full loop, then check data and status
    task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] ed, input logic [3:0] es);
        @(negedge clk);
        a = va;
        b = vb;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk({tag, "_data"}, dout, ed);
        chk({tag, "_stat"}, {28'd0, st}, {28'd0, es});
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", dout, 32'h0000_0000);
        chk("rst_stat", {28'd0, st}, {28'd0, EXA});

        // 2.0 + 1.0: first result lands on the fifth edge after release
        a = 32'h4000_0000;
        b = 32'h3FE0_0000;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("first_pre_data", dout, 32'h0000_0000);
        @(posedge clk);
        @(negedge clk);
        chk("first_data", dout, 32'h4010_0000);
        chk("first_stat", {28'd0, st}, {28'd0, EXA});

        // New operands loaded on the next edge; reset pulsed while in ADD
        a = 32'h4020_0000;
        b = 32'hBFE8_0000;
        @(posedge clk);
        @(posedge clk);
        #2000;
        rst_n = 1'b0;
        #1000;
        chk("midrst_data", dout, 32'h0000_0000);
        chk("midrst_stat", {28'd0, st}, {28'd0, EXA});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("after_rst_pre_data", dout, 32'h0000_0000);
        @(posedge clk);
        @(negedge clk);
        chk("after_rst_data", dout, 32'h400C_0000);
        chk("after_rst_stat", {28'd0, st}, {28'd0, EXA});

        run("three_plus_zero", 32'h4010_0000, 32'h0000_0000, 32'h4010_0000, EXA);
        run("neg2_plus_zero",  32'hC000_0000, 32'h0000_0000, 32'hC000_0000, EXA);
        run("zero_garbage",    32'h0001_2345, 32'h4000_0000, 32'h4000_0000, EXA);
        run("cancel",          32'h4040_0000, 32'hC040_0000, 32'h0000_0000, EXA);
        run("p4_5_twice",      32'h4024_0000, 32'h4024_0000, 32'h4044_0000, EXA);
        run("n4_5_twice",      32'hC024_0000, 32'hC024_0000, 32'hC044_0000, EXA);
        run("seven_minus3",    32'h4038_0000, 32'hC010_0000, 32'h4020_0000, EXA);
        run("sixteen_minus3",  32'h4060_0000, 32'hC010_0000, 32'h4054_0000, EXA);
        run("k1024_plus1",     32'h4120_0000, 32'h3FE0_0000, 32'h4120_0800, EXA);
        run("one_plus_2m23",   32'h3FE0_0000, 32'h3D00_0000, 32'h3FE0_0000, INX);
        run("tie_even_down",   32'h3FE0_0000, 32'h3D20_0000, 32'h3FE0_0000, INX);
        run("tie_odd_up",      32'h3FE0_0001, 32'h3D20_0000, 32'h3FE0_0002, INX);
        run("above_half",      32'h3FE0_0000, 32'h3D30_0000, 32'h3FE0_0001, INX);
        run("round_carry",     32'h3FFF_FFFF, 32'h3D30_0000, 32'h4000_0000, INX);
        run("sub_tie_carry",   32'h3FE0_0000, 32'hBD00_0000, 32'h3FE0_0000, INX);
        run("far_sticky",      32'h3FE0_0000, 32'h3C20_0000, 32'h3FE0_0000, INX);
        run("overflow",        32'h7FDF_FFFF, 32'h7FDF_FFFF, 32'h7FE0_0000, OVF);
        run("inf_pos",         32'h7FE0_0000, 32'h3FE0_0000, 32'h7FE0_0000, OVF);
        run("inf_neg",         32'hFFE0_0000, 32'h3FE0_0000, 32'hFFE0_0000, OVF);
        run("underflow",       32'h0020_0001, 32'h8020_0000, 32'h0000_0000, UNF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
